// File: rtl/xy2_pkg.sv
// Shared constants, state encoding and setpoint alignment helpers for the XY2-100 receiver.
package xy2_pkg;

  localparam int unsigned FRAME_BITS  = 20;
  localparam int unsigned SHIFT_BITS  = FRAME_BITS - 1;
  localparam logic [2:0]  CTRL16      = 3'b001;
  localparam logic [17:0] MIDSCALE    = 18'h20000;
  localparam logic [7:0]  ERR_CNT_MAX = 8'd255;

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StData  = 2'd1;
  localparam state_t StCheck = 2'd2;

  function automatic logic [17:0] align_setpoint(input logic mode_18b, input logic [18:0] frame);
    return mode_18b ? frame[17:0] : {frame[15:0], 2'b00};
  endfunction

  function automatic logic ctrl_ok(input logic mode_18b, input logic [18:0] frame);
    return mode_18b ? frame[18] : (frame[18:16] == CTRL16);
  endfunction

endpackage

// File: rtl/xy2_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with an optional falling-edge pulse.
module xy2_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter bit          FALL_EN = 1'b0
) (
  input  logic clk_in,
  input  logic cnt_rstn,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_in or negedge cnt_rstn) begin
    if (!cnt_rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

  if (FALL_EN) begin : g_fall
    logic prev_q;
    always_ff @(posedge clk_in or negedge cnt_rstn) begin
      if (!cnt_rstn) begin
        prev_q <= 1'b0;
      end else begin
        prev_q <= q_o;
      end
    end
    assign fall_o = prev_q & ~q_o;
  end else begin : g_no_fall
    assign fall_o = 1'b0;
  end

endmodule

// File: rtl/xy2_multi_rx.sv
// Multi-lane XY2-100(-E) setpoint receiver with framing/control/parity checks and link timeout.
// Define XY2_PARITY_CHECK_EN to enforce per-lane even parity; otherwise the parity bit is ignored.
module xy2_multi_rx
  import xy2_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 820
) (
  input  logic              clk_in,
  input  logic              cnt_rstn,
  input  logic              xy_clk,
  input  logic              xy_sync,
  input  logic [NCH-1:0]    xy_d,
  input  logic              mode_18b,
  input  logic              err_clr,
  output logic [NCH*18-1:0] sp_data,
  output logic              sp_valid,
  output logic [7:0]        err_cnt,
  output logic              link_lost,
  output logic              xy_status
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);

  logic           clk_s, clk_fall, sync_s, sync_fall_unused;
  logic [NCH-1:0] d_s, d_fall_unused;

  xy2_sync_edge #(.STAGES(SYNC_STAGES), .FALL_EN(1'b1)) u_clk_sync (
    .clk_in(clk_in), .cnt_rstn(cnt_rstn), .d_i(xy_clk), .q_o(clk_s), .fall_o(clk_fall)
  );

  xy2_sync_edge #(.STAGES(SYNC_STAGES), .FALL_EN(1'b0)) u_sync_sync (
    .clk_in(clk_in), .cnt_rstn(cnt_rstn), .d_i(xy_sync), .q_o(sync_s), .fall_o(sync_fall_unused)
  );

  for (genvar i = 0; i < NCH; i++) begin : g_d_sync
    xy2_sync_edge #(.STAGES(SYNC_STAGES), .FALL_EN(1'b0)) u_d_sync (
      .clk_in(clk_in), .cnt_rstn(cnt_rstn), .d_i(xy_d[i]), .q_o(d_s[i]),
      .fall_o(d_fall_unused[i])
    );
  end

  logic clk_s_unused;
  assign clk_s_unused = clk_s;

  state_t                state_q, state_d;
  logic                  armed_q, armed_d;
  logic [4:0]            count_q, count_d;
  logic [NCH-1:0][18:0]  shreg_q, shreg_d;
  logic [NCH-1:0]        par_q, par_d;
  logic                  mode_q, mode_d;
  logic [NCH-1:0][17:0]  sp_q, sp_d;
  logic                  sp_valid_q, sp_valid_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  sticky_q, sticky_d;
  logic [ToW-1:0]        to_cnt_q, to_cnt_d;
  logic                  link_lost_q, timeout;
  logic                  frame_err, frame_ok, err_evt;

  always_comb begin
    frame_ok = 1'b1;
    for (int i = 0; i < NCH; i++) begin
`ifdef XY2_PARITY_CHECK_EN
      if ((^shreg_q[i]) ^ par_q[i]) frame_ok = 1'b0;
`endif
      if (!ctrl_ok(mode_q, shreg_q[i])) frame_ok = 1'b0;
    end
  end

`ifndef XY2_PARITY_CHECK_EN
  logic par_unused;
  assign par_unused = ^par_q;
`endif

  always_comb begin
    if (clk_fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == ToW'(TIMEOUT_CYC)) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
  end
  assign timeout = (to_cnt_d == ToW'(TIMEOUT_CYC));

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    count_d   = count_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    mode_d    = mode_q;
    frame_err = 1'b0;
    case (state_q)
      StIdle: begin
        if (clk_fall) begin
          if (!sync_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            for (int i = 0; i < NCH; i++) shreg_d[i] = {shreg_q[i][17:0], d_s[i]};
            count_d = 5'd1;
            mode_d  = mode_18b;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (clk_fall) begin
          if (sync_s && (count_q < 5'(SHIFT_BITS))) begin
            for (int i = 0; i < NCH; i++) shreg_d[i] = {shreg_q[i][17:0], d_s[i]};
            count_d = count_q + 5'd1;
          end else if (!sync_s && (count_q == 5'(SHIFT_BITS))) begin
            par_d   = d_s;
            state_d = StCheck;
          end else begin
            frame_err = 1'b1;
            state_d   = StIdle;
            armed_d   = 1'b0;
          end
        end
      end
      StCheck: begin
        state_d = StIdle;
        armed_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
        armed_d = 1'b0;
      end
    endcase
    // A dead link discards any partial frame silently.
    if (timeout) begin
      state_d   = StIdle;
      armed_d   = 1'b0;
      frame_err = 1'b0;
    end
  end

  always_comb begin
    err_evt    = frame_err || ((state_q == StCheck) && !frame_ok);
    sp_valid_d = (state_q == StCheck) && frame_ok;
    for (int i = 0; i < NCH; i++) begin
      sp_d[i] = sp_valid_d ? align_setpoint(mode_q, shreg_q[i]) : sp_q[i];
    end
    if (err_evt) begin
      err_cnt_d = err_clr ? 8'd1 :
                  ((err_cnt_q == ERR_CNT_MAX) ? err_cnt_q : err_cnt_q + 8'd1);
      sticky_d  = 1'b1;
    end else if (err_clr) begin
      err_cnt_d = 8'd0;
      sticky_d  = 1'b0;
    end else begin
      err_cnt_d = err_cnt_q;
      sticky_d  = sticky_q;
    end
  end

  always_ff @(posedge clk_in or negedge cnt_rstn) begin
    if (!cnt_rstn) begin
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      count_q     <= '0;
      shreg_q     <= '0;
      par_q       <= '0;
      mode_q      <= 1'b0;
      sp_q        <= {NCH{MIDSCALE}};
      sp_valid_q  <= 1'b0;
      err_cnt_q   <= '0;
      sticky_q    <= 1'b0;
      to_cnt_q    <= '0;
      link_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      count_q     <= count_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      mode_q      <= mode_d;
      sp_q        <= sp_d;
      sp_valid_q  <= sp_valid_d;
      err_cnt_q   <= err_cnt_d;
      sticky_q    <= sticky_d;
      to_cnt_q    <= to_cnt_d;
      link_lost_q <= timeout;
    end
  end

  assign sp_data   = sp_q;
  assign sp_valid  = sp_valid_q;
  assign err_cnt   = err_cnt_q;
  assign link_lost = link_lost_q;
  assign xy_status = link_lost_q | sticky_q;

endmodule

// File: tb/tb_xy2_multi_rx.sv
// Directed bench for xy2_multi_rx: two lanes, hand-computed setpoints and error counts.
module tb_xy2_multi_rx;

  localparam int HALF = 8;

  logic        clk_in = 1'b0;
  logic        cnt_rstn = 1'b0;
  logic        xy_clk = 1'b0;
  logic        xy_sync = 1'b0;
  logic [1:0]  xy_d = 2'b00;
  logic        mode_18b = 1'b0;
  logic        err_clr = 1'b0;
  logic [35:0] sp_data;
  logic        sp_valid;
  logic [7:0]  err_cnt;
  logic        link_lost;
  logic        xy_status;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int exp_valid = 0;

  xy2_multi_rx #(.NCH(2), .SYNC_STAGES(2), .TIMEOUT_CYC(820)) dut (
    .clk_in(clk_in), .cnt_rstn(cnt_rstn), .xy_clk(xy_clk), .xy_sync(xy_sync), .xy_d(xy_d),
    .mode_18b(mode_18b), .err_clr(err_clr), .sp_data(sp_data), .sp_valid(sp_valid),
    .err_cnt(err_cnt), .link_lost(link_lost), .xy_status(xy_status)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (sp_valid === 1'b1) valid_cnt <= valid_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One XY2 bit: data changes with xy_clk rising, sampled on its falling edge.
  task automatic send_bit(input logic s, input logic [1:0] d, input logic clr);
    xy_sync = s;
    xy_d    = d;
    xy_clk  = 1'b1;
    repeat (HALF) @(negedge clk_in);
    xy_clk = 1'b0;
    repeat (2) @(negedge clk_in);
    err_clr = clr;
    @(negedge clk_in);
    err_clr = 1'b0;
    repeat (HALF - 3) @(negedge clk_in);
  endtask

  task automatic send_frame(input int n, input logic [18:0] w0, input logic [18:0] w1,
                            input logic flip1);
    for (int b = 18; b > 18 - n; b--) send_bit(1'b1, {w1[b], w0[b]}, 1'b0);
    if (n == 19) send_bit(1'b0, {(^w1) ^ flip1, ^w0}, 1'b0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk_in);
    err_clr = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    check("rst_sp_data", 64'(sp_data), 64'({18'h20000, 18'h20000}));
    check("rst_sp_valid", 64'(sp_valid), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_link_lost", 64'(link_lost), 64'd0);
    check("rst_xy_status", 64'(xy_status), 64'd0);
    cnt_rstn = 1'b1;
    @(negedge clk_in);
    send_bit(1'b0, 2'b00, 1'b0);

    // 16-bit frame on both lanes
    send_frame(19, {3'b001, 16'h1234}, {3'b001, 16'hABCD}, 1'b0);
    exp_valid++;
    check("a_sp_data", 64'(sp_data), 64'({18'h2AF34, 18'h048D0}));
    check("a_valid_cnt", 64'(valid_cnt), 64'(exp_valid));
    check("a_err_cnt", 64'(err_cnt), 64'd0);
    check("a_status", 64'(xy_status), 64'd0);

    // Back-to-back frame with lane 1 parity flipped
    send_frame(19, {3'b001, 16'h0001}, {3'b001, 16'h0002}, 1'b1);
`ifdef XY2_PARITY_CHECK_EN
    check("b_sp_held", 64'(sp_data), 64'({18'h2AF34, 18'h048D0}));
    check("b_err_cnt", 64'(err_cnt), 64'd1);
    check("b_status", 64'(xy_status), 64'd1);
`else
    exp_valid++;
    check("b_sp_data", 64'(sp_data), 64'({18'h00008, 18'h00004}));
    check("b_err_cnt", 64'(err_cnt), 64'd0);
`endif
    check("b_valid_cnt", 64'(valid_cnt), 64'(exp_valid));
    pulse_clr();
    check("b_clr_err_cnt", 64'(err_cnt), 64'd0);
    check("b_clr_status", 64'(xy_status), 64'd0);
    send_bit(1'b0, 2'b00, 1'b0);

    // 18-bit mode, control bit 1 then 0
    mode_18b = 1'b1;
    send_frame(19, {1'b1, 18'h3FFFF}, {1'b1, 18'h00005}, 1'b0);
    exp_valid++;
    check("e18_sp_data", 64'(sp_data), 64'({18'h00005, 18'h3FFFF}));
    check("e18_valid_cnt", 64'(valid_cnt), 64'(exp_valid));
    send_frame(19, {1'b0, 18'h3FFFF}, {1'b1, 18'h00005}, 1'b0);
    mode_18b = 1'b0;
    check("e18c0_sp_held", 64'(sp_data), 64'({18'h00005, 18'h3FFFF}));
    check("e18c0_err_cnt", 64'(err_cnt), 64'd1);
    check("e18c0_valid_cnt", 64'(valid_cnt), 64'(exp_valid));
    pulse_clr();

    // xy_clk stalls mid-frame for 900 cycles
    send_frame(7, {3'b001, 16'hFFFF}, {3'b001, 16'hFFFF}, 1'b0);
    repeat (815 - HALF) @(negedge clk_in);
    check("to_before", 64'(link_lost), 64'd0);
    repeat (15) @(negedge clk_in);
    check("to_lost", 64'(link_lost), 64'd1);
    check("to_status", 64'(xy_status), 64'd1);
    repeat (70) @(negedge clk_in);
    check("to_err_cnt", 64'(err_cnt), 64'd0);
    check("to_sp_held", 64'(sp_data), 64'({18'h00005, 18'h3FFFF}));
    send_bit(1'b0, 2'b00, 1'b0);
    check("to_recover", 64'(link_lost), 64'd0);
    send_frame(19, {3'b001, 16'h0F0F}, {3'b001, 16'h8001}, 1'b0);
    exp_valid++;
    check("to_next_sp", 64'(sp_data), 64'({18'h20004, 18'h03C3C}));
    check("to_next_err", 64'(err_cnt), 64'd0);

    // Sync dropped after 10 bits, then a good frame
    send_frame(10, {3'b001, 16'h1111}, {3'b001, 16'h2222}, 1'b0);
    send_bit(1'b0, 2'b00, 1'b0);
    check("drop_err_cnt", 64'(err_cnt), 64'd1);
    send_bit(1'b0, 2'b00, 1'b0);
    send_frame(19, {3'b001, 16'h5555}, {3'b001, 16'hAAAA}, 1'b0);
    exp_valid++;
    check("drop_next_sp", 64'(sp_data), 64'({18'h2AAA8, 18'h15554}));
    check("drop_next_err", 64'(err_cnt), 64'd1);
    check("drop_valid_cnt", 64'(valid_cnt), 64'(exp_valid));

    // 300 short frames, each a framing error
    for (int k = 0; k < 300; k++) begin
      send_bit(1'b0, 2'b00, 1'b0);
      send_bit(1'b1, 2'b11, 1'b0);
      send_bit(1'b0, 2'b00, 1'b0);
    end
    check("sat_err_cnt", 64'(err_cnt), 64'd255);
    check("sat_status", 64'(xy_status), 64'd1);

    // err_clr on the same cycle as a framing error
    pulse_clr();
    check("clr_err_cnt", 64'(err_cnt), 64'd0);
    send_bit(1'b0, 2'b00, 1'b0);
    send_bit(1'b1, 2'b00, 1'b0);
    send_bit(1'b0, 2'b00, 1'b1);
    check("clr_coinc_cnt", 64'(err_cnt), 64'd1);
    check("clr_coinc_status", 64'(xy_status), 64'd1);

    // Reset pulsed mid-frame
    send_bit(1'b0, 2'b00, 1'b0);
    send_frame(8, {3'b001, 16'h4321}, {3'b001, 16'h8765}, 1'b0);
    cnt_rstn = 1'b0;
    #1;
    check("mrst_sp_data", 64'(sp_data), 64'({18'h20000, 18'h20000}));
    check("mrst_err_cnt", 64'(err_cnt), 64'd0);
    check("mrst_status", 64'(xy_status), 64'd0);
    check("mrst_sp_valid", 64'(sp_valid), 64'd0);
    repeat (3) @(negedge clk_in);
    cnt_rstn = 1'b1;
    @(negedge clk_in);
    for (int k = 0; k < 11; k++) send_bit(1'b1, 2'b01, 1'b0);
    send_bit(1'b0, 2'b00, 1'b0);
    check("mrst_after_err", 64'(err_cnt), 64'd0);
    check("mrst_after_valid", 64'(valid_cnt), 64'(exp_valid));
    send_frame(19, {3'b001, 16'hFFFF}, {3'b001, 16'h0000}, 1'b0);
    exp_valid++;
    check("mrst_next_sp", 64'(sp_data), 64'({18'h00000, 18'h3FFFC}));
    check("mrst_next_valid", 64'(valid_cnt), 64'(exp_valid));
    check("mrst_next_err", 64'(err_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xy2_multi_rx.md
XY2_MULTI_RX -- requirements
Module: xy2_multi_rx

Interface
REQ-001 NCH, 2, number of XY2 data lanes (1..4); lane i on xy_d[i].
REQ-002 SYNC_STAGES, 2, synchroniser flops per async input (>=2).
REQ-003 TIMEOUT_CYC, 820, clk_in cycles without an xy_clk falling edge before link loss (10 us at 82 MHz).
REQ-004 clk_in  input  1  system clock, 82 MHz internal oscillator.
REQ-005 cnt_rstn  input  1  reset, asynchronous, active-low.
REQ-006 xy_clk  input  1  XY2-100 bit clock (2 MHz), asynchronous.
REQ-007 xy_sync  input  1  XY2-100 frame sync, asynchronous.
REQ-008 xy_d  input  NCH  per-lane serial data, asynchronous.
REQ-009 mode_18b  input  1  0: 16-bit frames; 1: 18-bit XY2-100-E frames; latched at frame start.
REQ-010 err_clr  input  1  one-cycle pulse; clears err_cnt and sticky error.
REQ-011 sp_data  output  NCH*18  setpoints; lane i at [18i+17:18i].
REQ-012 sp_valid  output  1  one-cycle pulse on sp_data update.
REQ-013 err_cnt  output  8  saturating count of rejected frames.
REQ-014 link_lost  output  1  high while the xy_clk timeout is active.
REQ-015 xy_status  output  1  link_lost OR sticky error; returned to the host.

Function
REQ-016 Synchronisation: every async input passes SYNC_STAGES flops; one bit is sampled per detected falling edge of synchronised xy_clk, using synchronised xy_sync/xy_d from the same cycle.
REQ-017 IDLE: wait for a sync=0 sample (armed); once armed, a sync=1 sample shifts bit into each lane's 19-bit register, sets count=1, latches mode_18b, moves to DATA.
REQ-018 DATA, sync=1, count<19: shift, count+1.
REQ-018a DATA, sync=0, count==19: capture per-lane parity bit, go CHECK.
REQ-018b DATA, sync=0 with count<19, or sync=1 with count==19: framing error, go IDLE unarmed.
REQ-019 CHECK, exactly one clk_in cycle: even parity per lane (XOR of 19 bits + parity = 0); control field bits[18:16]==3'b001 (16-bit) or bit[18]==1 (18-bit); then IDLE armed.
REQ-020 Acceptance: frame accepted only if all lanes pass; sp_data (all lanes) and sp_valid registered on the edge ending CHECK; latency 2 clk_in cycles from parity-bit sample.
REQ-021 Alignment: 16-bit mode emits {data[15:0],2'b00}; 18-bit mode emits data[17:0].
REQ-022 Rejection (framing, parity or control on any lane): sp_data held, no sp_valid, err_cnt +1 saturating at 255, sticky error set.
REQ-023 err_clr coincident with an error: err_cnt=1, sticky=1 (error wins).
REQ-024 Timeout: counter cleared on each detected xy_clk falling edge, else increments saturating at TIMEOUT_CYC; on reaching TIMEOUT_CYC link_lost=1, FSM forced to IDLE unarmed, partial frame discarded without error count.
REQ-025 Recovery: link_lost clears on the cycle after the next detected xy_clk falling edge; sp_data keeps the last accepted value throughout.
REQ-026 Back-to-back frames (parity sample followed by next sync=1 sample) SHALL lose no frame.

Reset
REQ-027 cnt_rstn low, asynchronous: FSM IDLE unarmed; sp_data every lane 18'h20000; sp_valid 0; err_cnt 0; sticky 0; link_lost 0; xy_status 0; timeout counter 0; synchronisers 0.
REQ-028 Reset asserted mid-frame: partial frame discarded with no error counted after release.

Configuration
REQ-029 XY2_PARITY_CHECK_EN defined: parity enforced per REQ-019.
REQ-029a XY2_PARITY_CHECK_EN undefined: parity bit captured but ignored; framing and control checks unchanged.

Structure
REQ-030 Package xy2_pkg: FSM state enum (IDLE, DATA, CHECK), FRAME_BITS=20, CTRL16=3'b001, MIDSCALE=18'h20000, ERR_CNT_MAX=255.
REQ-031 Sub-module xy2_sync_edge: SYNC_STAGES synchroniser with optional falling-edge pulse output; one instance per async input.

Verification
REQ-032 NCH=2, 16-bit mode, lane0=0x1234, lane1=0xABCD, good parity -> sp_data={18'h2AF34,18'h048D0}, one sp_valid pulse, err_cnt 0.
REQ-033 Lane1 parity flipped, macro defined -> sp_data held, err_cnt 1, xy_status 1; err_clr -> err_cnt 0, xy_status 0. Macro undefined -> frame accepted.
REQ-034 mode_18b=1, lane0=18'h3FFFF, ctrl 1 -> lane0 18'h3FFFF; same frame with ctrl 0 -> rejected, err_cnt +1.
REQ-035 xy_clk stopped 900 cycles mid-frame -> link_lost=1 820 cycles after last edge, err_cnt unchanged; clock resumes -> link_lost clears, next full frame accepted.
REQ-036 Sync dropped after 10 bits -> err_cnt 1, following frame accepted; 300 consecutive bad frames -> err_cnt 255.
REQ-037 cnt_rstn pulsed mid-frame -> outputs at reset values immediately, no error after release, next full frame accepted.
